// File: rtl/gnr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gnr_pkg                                                                    |
// | Shared defaults, action encoding and helpers for GNR network node blocks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gnr_pkg;

    localparam int unsigned DEF_PER_W = 4;
    localparam int unsigned DEF_STB_W = 8;

    // Per-cycle action of a node channel, listed in increasing priority.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_START = 2'd1,
        ACT_NOS   = 2'd2,
        ACT_RST   = 2'd3
    } node_act_e;

    function automatic node_act_e pri_encode(
        input logic rst_req,
        input logic nos_req,
        input logic stb_req
    );
        node_act_e act;
        act = ACT_HOLD;
        if (rst_req)      act = ACT_RST;
        else if (nos_req) act = ACT_NOS;
        else if (stb_req) act = ACT_START;
        return act;
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic [31:0] max_val
    );
        return (val >= max_val) ? max_val : (val + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnr_node_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gnr_node_ch                                                                |
// | One node channel: state bit, period skip counter, update/change pulses and |
// | stability counter (present only when GNR_STABLE_DET_EN is defined).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gnr_node_ch
    import gnr_pkg::*;
#(
    parameter int unsigned PER_W     = DEF_PER_W,
    parameter int unsigned STB_W     = DEF_STB_W,
    parameter int unsigned STABLE_TH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_nos,
    input  logic             init_state,
    input  logic             start,
    input  logic             next_state,
    input  logic [PER_W-1:0] period,
    output logic             s,
    output logic             upd,
    output logic             changed,
    output logic             stable
);

    node_act_e        w_act;
    logic             w_take;
    logic             r_s;
    logic             r_upd;
    logic             r_changed;
    logic [PER_W-1:0] r_cnt;

    assign w_act  = pri_encode(rst, reset_nos, start);
    // cnt >= period lets a lowered period take effect on the very next strobe
    assign w_take = (r_cnt >= period);

    always_ff @(posedge clk) begin
        r_upd     <= 1'b0;
        r_changed <= 1'b0;
        if (rst) begin
            r_s   <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (w_act)
                ACT_NOS: begin
                    r_s   <= init_state;
                    r_cnt <= period;
                end
                ACT_START: begin
                    if (w_take) begin
                        r_s       <= next_state;
                        r_cnt     <= '0;
                        r_upd     <= 1'b1;
                        r_changed <= (next_state != r_s);
                    end else begin
                        r_cnt <= r_cnt + PER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s       = r_s;
    assign upd     = r_upd;
    assign changed = r_changed;

`ifdef GNR_STABLE_DET_EN
    localparam logic [31:0] STAB_MAX = 32'((64'd1 << STB_W) - 64'd1);
    localparam logic [31:0] STAB_TH  = 32'(STABLE_TH);

    logic [STB_W-1:0] r_stab_cnt;
    logic [STB_W-1:0] w_stab_nxt;
    logic             r_stable;

    // stable is derived from the next count so it rises with the qualifying upd pulse
    always_comb begin
        w_stab_nxt = r_stab_cnt;
        case (w_act)
            ACT_RST, ACT_NOS: w_stab_nxt = '0;
            ACT_START: begin
                if (w_take) begin
                    if (next_state != r_s) w_stab_nxt = '0;
                    else                   w_stab_nxt = STB_W'(sat_inc(32'(r_stab_cnt), STAB_MAX));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stab_cnt <= '0;
            r_stable   <= 1'b0;
        end else begin
            r_stab_cnt <= w_stab_nxt;
            r_stable   <= (32'(w_stab_nxt) >= STAB_TH);
        end
    end

    assign stable = r_stable;
`else
    assign stable = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/gnr_node_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gnr_node_mc                                                                |
// | Multi-channel Boolean-network node; one independent stream per channel.    |
// | Optional stability detector: define GNR_STABLE_DET_EN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gnr_node_mc
    import gnr_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned PER_W     = DEF_PER_W,
    parameter int unsigned STB_W     = DEF_STB_W,
    parameter int unsigned STABLE_TH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_nos,
    input  logic [NCH-1:0]   init_state,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   next_state,
    input  logic [PER_W-1:0] period,
    output logic [NCH-1:0]   s,
    output logic [NCH-1:0]   upd,
    output logic [NCH-1:0]   changed,
    output logic [NCH-1:0]   stable
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gnr_node_ch #(
            .PER_W     (PER_W),
            .STB_W     (STB_W),
            .STABLE_TH (STABLE_TH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .reset_nos  (reset_nos),
            .init_state (init_state[i]),
            .start      (start[i]),
            .next_state (next_state[i]),
            .period     (period),
            .s          (s[i]),
            .upd        (upd[i]),
            .changed    (changed[i]),
            .stable     (stable[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_gnr_node_mc.sv
`default_nettype none
// Directed and model-based bench for gnr_node_mc (NCH=4, STABLE_TH=4).
module tb_gnr_node_mc;

    localparam int NCH       = 4;
    localparam int PER_W     = 4;
    localparam int STB_W     = 8;
    localparam int STABLE_TH = 4;
`ifdef GNR_STABLE_DET_EN
    localparam bit STAB_EN = 1'b1;
`else
    localparam bit STAB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             reset_nos;
    logic [NCH-1:0]   init_state;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   next_state;
    logic [PER_W-1:0] period;
    logic [NCH-1:0]   s;
    logic [NCH-1:0]   upd;
    logic [NCH-1:0]   changed;
    logic [NCH-1:0]   stable;

    int checks = 0;
    int errors = 0;

    gnr_node_mc #(
        .NCH       (NCH),
        .PER_W     (PER_W),
        .STB_W     (STB_W),
        .STABLE_TH (STABLE_TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start      (start),
        .next_state (next_state),
        .period     (period),
        .s          (s),
        .upd        (upd),
        .changed    (changed),
        .stable     (stable)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1; reset_nos = 1'b0; start = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reset_nos = 1'b1; init_state = '1; start = '1; next_state = '1; period = '0;
        cyc();
        cyc();
        checks++; if (s !== 4'b0000)       begin errors++; $display("FAIL reset_s: got %b expected 0000", s); end
        checks++; if (upd !== 4'b0000)     begin errors++; $display("FAIL reset_upd: got %b expected 0000", upd); end
        checks++; if (changed !== 4'b0000) begin errors++; $display("FAIL reset_changed: got %b expected 0000", changed); end
        checks++; if (stable !== 4'b0000)  begin errors++; $display("FAIL reset_stable: got %b expected 0000", stable); end
        rst = 1'b0; reset_nos = 1'b0; start = '0;
        cyc();
    endtask

    // Channels 0/1 strobed back to back from init=1 with next_state=0.
    task automatic test_period(input logic [PER_W-1:0] per, input logic [3:0] exp_upd);
        logic [3:0] exp_chg;
        exp_chg = 4'b0001;
        period = per;
        reset_nos = 1'b1; init_state = '1; start = '0;
        cyc();
        reset_nos = 1'b0;
        checks++; if (s !== 4'b1111) begin errors++; $display("FAIL p%0d_init_s: got %b expected 1111", per, s); end
        for (int k = 0; k < 4; k++) begin
            start = 4'b0011; next_state = 4'b0000;
            cyc();
            checks++;
            if (upd[1:0] !== {2{exp_upd[k]}}) begin
                errors++; $display("FAIL p%0d_upd_strobe%0d: got %b expected %b", per, k + 1, upd[1:0], {2{exp_upd[k]}});
            end
            checks++;
            if (s !== 4'b1100) begin
                errors++; $display("FAIL p%0d_s_strobe%0d: got %b expected 1100", per, k + 1, s);
            end
            checks++;
            if (changed[1:0] !== {2{exp_chg[k]}}) begin
                errors++; $display("FAIL p%0d_chg_strobe%0d: got %b expected %b", per, k + 1, changed[1:0], {2{exp_chg[k]}});
            end
        end
        start = '0;
        cyc();
        checks++; if (upd !== 4'b0000) begin errors++; $display("FAIL p%0d_idle_upd: got %b expected 0000", per, upd); end
    endtask

    task automatic test_post_rst_skip();
        period = 4'd2;
        do_rst();
        for (int k = 1; k <= 3; k++) begin
            start = 4'b0001; next_state = 4'b1111;
            cyc();
            checks++;
            if (upd[0] !== (k == 3)) begin errors++; $display("FAIL postrst_upd_strobe%0d: got %b expected %b", k, upd[0], (k == 3)); end
            checks++;
            if (s[0] !== (k == 3)) begin errors++; $display("FAIL postrst_s_strobe%0d: got %b expected %b", k, s[0], (k == 3)); end
        end
        checks++; if (changed[0] !== 1'b1) begin errors++; $display("FAIL postrst_changed: got %b expected 1", changed[0]); end
        start = '0;
        cyc();
    endtask

    task automatic test_simultaneous();
        period = 4'd0;
        reset_nos = 1'b1; init_state = 4'b0000; start = 4'b0001; next_state = 4'b0001;
        cyc();
        reset_nos = 1'b0;
        checks++; if (s[0] !== 1'b0)   begin errors++; $display("FAIL simul_s: got %b expected 0", s[0]); end
        checks++; if (upd[0] !== 1'b0) begin errors++; $display("FAIL simul_upd: got %b expected 0", upd[0]); end
        cyc();
        checks++; if (s[0] !== 1'b1)       begin errors++; $display("FAIL simul_next_s: got %b expected 1", s[0]); end
        checks++; if (upd[0] !== 1'b1)     begin errors++; $display("FAIL simul_next_upd: got %b expected 1", upd[0]); end
        checks++; if (changed[0] !== 1'b1) begin errors++; $display("FAIL simul_next_changed: got %b expected 1", changed[0]); end
        start = '0;
        cyc();
    endtask

    task automatic test_period_shrink();
        period = 4'd7;
        do_rst();
        for (int k = 0; k < 3; k++) begin
            start = 4'b0001; next_state = 4'b0001;
            cyc();
            checks++; if (upd[0] !== 1'b0) begin errors++; $display("FAIL shrink_skip%0d_upd: got %b expected 0", k + 1, upd[0]); end
        end
        period = 4'd2;
        cyc();
        checks++; if (upd[0] !== 1'b1) begin errors++; $display("FAIL shrink_upd: got %b expected 1", upd[0]); end
        checks++; if (s[0] !== 1'b1)   begin errors++; $display("FAIL shrink_s: got %b expected 1", s[0]); end
        start = '0;
        cyc();
    endtask

    task automatic test_stable();
        period = 4'd0;
        reset_nos = 1'b1; init_state = 4'b0000; start = '0;
        cyc();
        reset_nos = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            start = 4'b0001; next_state = 4'b0000;
            cyc();
            checks++;
            if (stable[0] !== (STAB_EN && k == 4)) begin
                errors++; $display("FAIL stable_upd%0d: got %b expected %b", k, stable[0], (STAB_EN && k == 4));
            end
            checks++; if (upd[0] !== 1'b1) begin errors++; $display("FAIL stable_upd%0d_pulse: got %b expected 1", k, upd[0]); end
        end
        start = '0;
        cyc();
        checks++; if (stable[0] !== STAB_EN) begin errors++; $display("FAIL stable_hold: got %b expected %b", stable[0], STAB_EN); end
        start = 4'b0001; next_state = 4'b0001;
        cyc();
        checks++; if (stable[0] !== 1'b0)  begin errors++; $display("FAIL stable_fall: got %b expected 0", stable[0]); end
        checks++; if (changed[0] !== 1'b1) begin errors++; $display("FAIL stable_fall_changed: got %b expected 1", changed[0]); end
        start = '0;
        cyc();
    endtask

    task automatic test_random();
        logic [NCH-1:0] m_s, e_upd, e_chg, e_stab;
        int m_cnt [NCH];
        int m_stab [NCH];
        period = 4'd1;
        do_rst();
        m_s = '0;
        for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_stab[c] = 0; end
        for (int n = 0; n < 1000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            reset_nos  = ($urandom_range(0, 31) == 0);
            init_state = NCH'($urandom);
            start      = NCH'($urandom);
            next_state = NCH'($urandom);
            if ($urandom_range(0, 15) == 0) period = PER_W'($urandom_range(0, 3));
            e_upd = '0; e_chg = '0;
            for (int c = 0; c < NCH; c++) begin
                if (rst) begin
                    m_s[c] = 1'b0; m_cnt[c] = 0; m_stab[c] = 0;
                end else if (reset_nos) begin
                    m_s[c] = init_state[c]; m_cnt[c] = int'(period); m_stab[c] = 0;
                end else if (start[c]) begin
                    if (m_cnt[c] >= int'(period)) begin
                        e_upd[c] = 1'b1;
                        e_chg[c] = (next_state[c] != m_s[c]);
                        m_s[c]   = next_state[c];
                        m_cnt[c] = 0;
                        if (e_chg[c]) m_stab[c] = 0;
                        else if (m_stab[c] < (1 << STB_W) - 1) m_stab[c] = m_stab[c] + 1;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                end
                e_stab[c] = STAB_EN && (m_stab[c] >= STABLE_TH);
            end
            cyc();
            checks++; if (s !== m_s)          begin errors++; $display("FAIL rand_s cyc %0d: got %b expected %b", n, s, m_s); end
            checks++; if (upd !== e_upd)      begin errors++; $display("FAIL rand_upd cyc %0d: got %b expected %b", n, upd, e_upd); end
            checks++; if (changed !== e_chg)  begin errors++; $display("FAIL rand_changed cyc %0d: got %b expected %b", n, changed, e_chg); end
            checks++; if (stable !== e_stab)  begin errors++; $display("FAIL rand_stable cyc %0d: got %b expected %b", n, stable, e_stab); end
        end
        rst = 1'b0; reset_nos = 1'b0; start = '0;
    endtask

    initial begin
        rst = 1'b1; reset_nos = 1'b0; init_state = '0; start = '0; next_state = '0; period = '0;
        test_reset();
        test_period(4'd0, 4'b1111);
        test_period(4'd1, 4'b0101);
        test_post_rst_skip();
        test_simultaneous();
        test_period_shrink();
        test_stable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
